// File: rtl/lloyd_max_engine.sv
// rtl/lloyd_max_engine.sv - iterative Lloyd-Max scalar quantiser designer
module lloyd_max_engine #(
    parameter int DATA_BITS  = 8,
    parameter int NUM_LEVELS = 4,
    parameter int FRAC_BITS  = 8,
    parameter int CNT_BITS   = 16,
    parameter int MAX_ITER   = 16,
    parameter int TOL        = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hist_wr_en,
    input  logic [DATA_BITS-1:0]           hist_wr_addr,
    input  logic [CNT_BITS-1:0]            hist_wr_data,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           converged,
    output logic [7:0]                     iter_count,
    input  logic [3:0]                     rd_idx,
    output logic [DATA_BITS+FRAC_BITS-1:0] level_out,
    output logic [DATA_BITS+FRAC_BITS-1:0] boundary_out
);

    localparam int W    = DATA_BITS + FRAC_BITS;
    localparam int CW   = CNT_BITS + DATA_BITS;
    localparam int SW   = CNT_BITS + 2 * DATA_BITS;
    localparam int NB   = NUM_LEVELS - 1;
    localparam int BINS = 1 << DATA_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ACCUM, S_DIVIDE, S_UPDATE, S_CHECK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              conv_q, conv_d;
    logic [7:0]        iter_q, iter_d;
    logic [W-1:0]      lvl_out_q, lvl_out_d;
    logic [W-1:0]      bnd_out_q, bnd_out_d;
    logic [W-1:0]      a_q     [NUM_LEVELS];
    logic [W-1:0]      a_d     [NUM_LEVELS];
    logic [W-1:0]      new_a_q [NUM_LEVELS];
    logic [W-1:0]      new_a_d [NUM_LEVELS];
    logic [W-1:0]      bnd_q   [NB];
    logic [W-1:0]      bnd_d   [NB];
    logic [CW-1:0]     cnt_q   [NUM_LEVELS];
    logic [CW-1:0]     cnt_d   [NUM_LEVELS];
    logic [SW-1:0]     sum_q   [NUM_LEVELS];
    logic [SW-1:0]     sum_d   [NUM_LEVELS];
    logic [W-1:0]      maxdelta_q, maxdelta_d;
    logic [DATA_BITS-1:0] scan_q, scan_d;
    logic [4:0]        div_r_q, div_r_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [W-1:0]      dlo_q, dlo_d;

    logic [CNT_BITS-1:0] hist_mem [BINS];

    function automatic logic [W-1:0] init_level(input int k);
        longint unsigned v;
        v = (64'(2 * k + 1) << W) / 64'(2 * NUM_LEVELS);
        return W'(v);
    endfunction

    function automatic logic [W-1:0] midpoint(input logic [W-1:0] lo, input logic [W-1:0] hi);
        logic [W:0] s;
        s = {1'b0, lo} + {1'b0, hi};
        return s[W:1];
    endfunction

    always_ff @(posedge clk) begin
        if (hist_wr_en && !busy_q) begin
            hist_mem[hist_wr_addr] <= hist_wr_data;
        end
    end

    logic [W-1:0]        xs;
    logic [4:0]          region;
    logic [CNT_BITS-1:0] hval;
    logic [SW-1:0]       prod;

    // Region of the scanned bin = number of boundaries at or below it.
    always_comb begin
        xs     = {scan_q, {FRAC_BITS{1'b0}}};
        hval   = hist_mem[scan_q];
        prod   = SW'(hval) * SW'(scan_q);
        region = '0;
        for (int k = 0; k < NB; k++) begin
            if (bnd_q[k] <= xs) region = region + 5'd1;
        end
    end

    logic [CW-1:0] cur_cnt;
    logic [SW-1:0] cur_sum;
    logic [W-1:0]  cur_a;
    logic [CW:0]   trial;
    logic          fits;
    logic [CW-1:0] rem_next;
    logic [W-1:0]  quo_next;

    // dlo_q shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        cur_cnt = '0;
        cur_sum = '0;
        cur_a   = '0;
        for (int r = 0; r < NUM_LEVELS; r++) begin
            if (div_r_q == 5'(r)) begin
                cur_cnt = cnt_q[r];
                cur_sum = sum_q[r];
                cur_a   = a_q[r];
            end
        end
        trial    = {rem_q, dlo_q[W-1]};
        fits     = trial >= {1'b0, cur_cnt};
        rem_next = fits ? CW'(trial - {1'b0, cur_cnt}) : CW'(trial);
        quo_next = {dlo_q[W-2:0], fits};
    end

    logic [W-1:0] delta;
    logic [W-1:0] maxd;
    logic [W-1:0] init_a [NUM_LEVELS];

    always_comb begin
        maxd  = '0;
        delta = '0;
        for (int r = 0; r < NUM_LEVELS; r++) begin
            delta = (new_a_q[r] >= a_q[r]) ? new_a_q[r] - a_q[r] : a_q[r] - new_a_q[r];
            if (delta > maxd) maxd = delta;
            init_a[r] = init_level(r);
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conv_d     = conv_q;
        iter_d     = iter_q;
        maxdelta_d = maxdelta_q;
        scan_d     = scan_q;
        div_r_d    = div_r_q;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        dlo_d      = dlo_q;
        for (int r = 0; r < NUM_LEVELS; r++) begin
            a_d[r]     = a_q[r];
            new_a_d[r] = new_a_q[r];
            cnt_d[r]   = cnt_q[r];
            sum_d[r]   = sum_q[r];
        end
        for (int k = 0; k < NB; k++) bnd_d[k] = bnd_q[k];

        lvl_out_d = '0;
        bnd_out_d = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (rd_idx == 4'(k)) lvl_out_d = a_q[k];
        end
        for (int k = 0; k < NB; k++) begin
            if (rd_idx == 4'(k)) bnd_out_d = bnd_q[k];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                end
            end
            S_INIT: begin
                for (int r = 0; r < NUM_LEVELS; r++) begin
                    a_d[r]   = init_a[r];
                    cnt_d[r] = '0;
                    sum_d[r] = '0;
                end
                for (int k = 0; k < NB; k++) bnd_d[k] = midpoint(init_a[k], init_a[k+1]);
                iter_d  = '0;
                conv_d  = 1'b0;
                scan_d  = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                for (int r = 0; r < NUM_LEVELS; r++) begin
                    if (region == 5'(r)) begin
                        cnt_d[r] = cnt_q[r] + CW'(hval);
                        sum_d[r] = sum_q[r] + prod;
                    end
                end
                scan_d = scan_q + 1'b1;
                if (scan_q == {DATA_BITS{1'b1}}) begin
                    state_d   = S_DIVIDE;
                    div_r_d   = '0;
                    div_cnt_d = '0;
                end
            end
            S_DIVIDE: begin
                if (div_cnt_q == 8'd0) begin
                    rem_d     = cur_sum[SW-1:DATA_BITS];
                    dlo_d     = {cur_sum[DATA_BITS-1:0], {FRAC_BITS{1'b0}}};
                    div_cnt_d = 8'd1;
                end else begin
                    rem_d     = rem_next;
                    dlo_d     = quo_next;
                    div_cnt_d = div_cnt_q + 8'd1;
                    if (div_cnt_q == 8'(W)) begin
                        // An empty region keeps its previous level.
                        for (int r = 0; r < NUM_LEVELS; r++) begin
                            if (div_r_q == 5'(r)) new_a_d[r] = (cur_cnt == '0) ? cur_a : quo_next;
                        end
                        div_cnt_d = 8'd0;
                        if (div_r_q == 5'(NUM_LEVELS - 1)) state_d = S_UPDATE;
                        else div_r_d = div_r_q + 5'd1;
                    end
                end
            end
            S_UPDATE: begin
                maxdelta_d = maxd;
                for (int r = 0; r < NUM_LEVELS; r++) a_d[r] = new_a_q[r];
                for (int k = 0; k < NB; k++) bnd_d[k] = midpoint(new_a_q[k], new_a_q[k+1]);
                iter_d  = iter_q + 8'd1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (maxdelta_q <= W'(TOL)) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (iter_q == 8'(MAX_ITER)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    for (int r = 0; r < NUM_LEVELS; r++) begin
                        cnt_d[r] = '0;
                        sum_d[r] = '0;
                    end
                    scan_d  = '0;
                    state_d = S_ACCUM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            iter_q     <= '0;
            lvl_out_q  <= '0;
            bnd_out_q  <= '0;
            maxdelta_q <= '0;
            scan_q     <= '0;
            div_r_q    <= '0;
            div_cnt_q  <= '0;
            rem_q      <= '0;
            dlo_q      <= '0;
            for (int r = 0; r < NUM_LEVELS; r++) begin
                a_q[r]     <= '0;
                new_a_q[r] <= '0;
                cnt_q[r]   <= '0;
                sum_q[r]   <= '0;
            end
            for (int k = 0; k < NB; k++) bnd_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conv_q     <= conv_d;
            iter_q     <= iter_d;
            lvl_out_q  <= lvl_out_d;
            bnd_out_q  <= bnd_out_d;
            maxdelta_q <= maxdelta_d;
            scan_q     <= scan_d;
            div_r_q    <= div_r_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            dlo_q      <= dlo_d;
            for (int r = 0; r < NUM_LEVELS; r++) begin
                a_q[r]     <= a_d[r];
                new_a_q[r] <= new_a_d[r];
                cnt_q[r]   <= cnt_d[r];
                sum_q[r]   <= sum_d[r];
            end
            for (int k = 0; k < NB; k++) bnd_q[k] <= bnd_d[k];
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign converged    = conv_q;
    assign iter_count   = iter_q;
    assign level_out    = lvl_out_q;
    assign boundary_out = bnd_out_q;

endmodule

// File: tb/tb_lloyd_max_engine.sv
// tb/tb_lloyd_max_engine.sv - scoreboard bench for lloyd_max_engine
module tb_lloyd_max_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wr_en   [3];
    logic [7:0]  wr_addr [3];
    logic [15:0] wr_data [3];
    logic        start   [3];
    logic [3:0]  rd_idx  [3];
    logic        busy    [3];
    logic        done    [3];
    logic        conv    [3];
    logic [7:0]  iter    [3];
    logic [15:0] lvl     [3];
    logic [15:0] bnd     [3];

    int checks   = 0;
    int failures = 0;

    int unsigned exp_q  [$];
    string       name_q [$];
    int unsigned obs_q  [$];
    int unsigned hist_t [256];

    lloyd_max_engine u_def (
        .clk(clk), .reset(reset), .hist_wr_en(wr_en[0]), .hist_wr_addr(wr_addr[0]),
        .hist_wr_data(wr_data[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .converged(conv[0]), .iter_count(iter[0]), .rd_idx(rd_idx[0]),
        .level_out(lvl[0]), .boundary_out(bnd[0])
    );

    lloyd_max_engine #(.NUM_LEVELS(2)) u_l2 (
        .clk(clk), .reset(reset), .hist_wr_en(wr_en[1]), .hist_wr_addr(wr_addr[1]),
        .hist_wr_data(wr_data[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .converged(conv[1]), .iter_count(iter[1]), .rd_idx(rd_idx[1]),
        .level_out(lvl[1]), .boundary_out(bnd[1])
    );

    lloyd_max_engine #(.MAX_ITER(1)) u_cap (
        .clk(clk), .reset(reset), .hist_wr_en(wr_en[2]), .hist_wr_addr(wr_addr[2]),
        .hist_wr_data(wr_data[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .converged(conv[2]), .iter_count(iter[2]), .rd_idx(rd_idx[2]),
        .level_out(lvl[2]), .boundary_out(bnd[2])
    );

    task automatic push_exp(input string n, input int unsigned v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic push_result(input int unsigned c, input int unsigned it,
                               input int unsigned l0, input int unsigned l1,
                               input int unsigned l2, input int unsigned l3,
                               input int unsigned b0, input int unsigned b1,
                               input int unsigned b2, input int nl);
        int unsigned lv [4];
        int unsigned bv [4];
        lv = '{l0, l1, l2, l3};
        bv = '{b0, b1, b2, 0};
        push_exp("converged", c);
        push_exp("iter_count", it);
        for (int i = 0; i < nl; i++) begin
            push_exp($sformatf("level[%0d]", i), lv[i]);
            push_exp($sformatf("boundary[%0d]", i), (i < nl - 1) ? bv[i] : 0);
        end
    endtask

    task automatic load_hist(input int d);
        for (int x = 0; x < 256; x++) begin
            @(negedge clk);
            wr_en[d]   = 1'b1;
            wr_addr[d] = 8'(x);
            wr_data[d] = 16'(hist_t[x]);
        end
        @(negedge clk);
        wr_en[d] = 1'b0;
    endtask

    task automatic kick(input int d, output logic busy_seen);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        busy_seen = busy[d];
    endtask

    task automatic wait_done(input int d, output bit timed_out,
                             output logic busy_at_done, output logic done_after);
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done[d] === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        busy_at_done = busy[d];
        @(negedge clk);
        done_after = done[d];
    endtask

    task automatic collect(input int d, input int nl);
        obs_q.push_back(32'(conv[d]));
        obs_q.push_back(32'(iter[d]));
        for (int i = 0; i < nl; i++) begin
            rd_idx[d] = 4'(i);
            @(negedge clk);
            obs_q.push_back(32'(lvl[d]));
            obs_q.push_back(32'(bnd[d]));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks += 6;
            if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy[d]); end
            if (done[d] !== 1'b0) begin failures++; $display("FAIL reset_done dut%0d got=%b exp=0", d, done[d]); end
            if (conv[d] !== 1'b0) begin failures++; $display("FAIL reset_converged dut%0d got=%b exp=0", d, conv[d]); end
            if (iter[d] !== 8'd0) begin failures++; $display("FAIL reset_iter dut%0d got=%0d exp=0", d, iter[d]); end
            if (lvl[d] !== 16'd0) begin failures++; $display("FAIL reset_level dut%0d got=0x%0h exp=0", d, lvl[d]); end
            if (bnd[d] !== 16'd0) begin failures++; $display("FAIL reset_boundary dut%0d got=0x%0h exp=0", d, bnd[d]); end
        end
        reset = 1'b0;
    endtask

    task automatic run_and_score(input string tag, input int d, input int nl);
        logic b0, bd, da;
        bit   to;
        kick(d, b0);
        wait_done(d, to, bd, da);
        checks += 4;
        if (b0 !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b exp=1", tag, b0); end
        if (to) begin failures++; $display("FAIL %s done_timeout got=no_done exp=done", tag); end
        if (bd !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b exp=0", tag, bd); end
        if (da !== 1'b0) begin failures++; $display("FAIL %s done_pulse_width got=%b exp=0", tag, da); end
        collect(d, nl);
        while (exp_q.size() > 0) begin
            string       n;
            int unsigned e, o;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s %s got=0x%0h exp=0x%0h", tag, n, o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_uniform();
        for (int x = 0; x < 256; x++) hist_t[x] = 1;
        load_hist(0);
        push_result(1, 2, 'h1F80, 'h5F80, 'h9F80, 'hDF80, 'h3F80, 'h7F80, 'hBF80, 4);
        run_and_score("uniform", 0, 4);
    endtask

    task automatic test_two_spikes();
        for (int x = 0; x < 256; x++) hist_t[x] = 0;
        hist_t[10]  = 5;
        hist_t[200] = 3;
        load_hist(1);
        push_result(1, 2, 'h0A00, 'hC800, 0, 0, 'h6900, 0, 0, 2);
        run_and_score("two_spikes", 1, 2);
    endtask

    task automatic test_empty_region();
        for (int x = 0; x < 256; x++) hist_t[x] = 0;
        hist_t[5] = 4;
        load_hist(1);
        push_result(1, 2, 'h0500, 'hC000, 0, 0, 'h6280, 0, 0, 2);
        run_and_score("empty_region", 1, 2);
    endtask

    task automatic test_iter_cap();
        for (int x = 0; x < 256; x++) hist_t[x] = 1;
        load_hist(2);
        push_result(0, 1, 'h1F80, 'h5F80, 'h9F80, 'hDF80, 'h3F80, 'h7F80, 'hBF80, 4);
        run_and_score("iter_cap", 2, 4);
    endtask

    task automatic test_abort();
        logic b0;
        rd_idx[0] = 4'd0;
        kick(0, b0);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 7;
        if (b0 !== 1'b1) begin failures++; $display("FAIL abort busy_after_start got=%b exp=1", b0); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy[0]); end
        if (done[0] !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done[0]); end
        if (conv[0] !== 1'b0) begin failures++; $display("FAIL abort_converged got=%b exp=0", conv[0]); end
        if (iter[0] !== 8'd0) begin failures++; $display("FAIL abort_iter got=%0d exp=0", iter[0]); end
        if (lvl[0] !== 16'd0) begin failures++; $display("FAIL abort_level got=0x%0h exp=0", lvl[0]); end
        if (bnd[0] !== 16'd0) begin failures++; $display("FAIL abort_boundary got=0x%0h exp=0", bnd[0]); end
        reset = 1'b0;
        @(negedge clk);
        push_result(1, 2, 'h1F80, 'h5F80, 'h9F80, 'hDF80, 'h3F80, 'h7F80, 'hBF80, 4);
        run_and_score("after_abort", 0, 4);
    endtask

    task automatic test_busy_ignore();
        logic b0, bd, da;
        bit   to;
        push_result(1, 2, 'h1F80, 'h5F80, 'h9F80, 'hDF80, 'h3F80, 'h7F80, 'hBF80, 4);
        kick(0, b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            start[0]   = 1'b1;
            wr_en[0]   = 1'b1;
            wr_addr[0] = 8'(i * 7);
            wr_data[0] = 16'd1000;
            @(negedge clk);
        end
        start[0] = 1'b0;
        wr_en[0] = 1'b0;
        wait_done(0, to, bd, da);
        checks += 4;
        if (b0 !== 1'b1) begin failures++; $display("FAIL busy_ignore busy_after_start got=%b exp=1", b0); end
        if (to) begin failures++; $display("FAIL busy_ignore done_timeout got=no_done exp=done"); end
        if (bd !== 1'b0) begin failures++; $display("FAIL busy_ignore busy_at_done got=%b exp=0", bd); end
        if (da !== 1'b0) begin failures++; $display("FAIL busy_ignore done_pulse_width got=%b exp=0", da); end
        collect(0, 4);
        while (exp_q.size() > 0) begin
            string       n;
            int unsigned e, o;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL busy_ignore %s got=0x%0h exp=0x%0h", n, o, e);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            wr_en[d]   = 1'b0;
            wr_addr[d] = '0;
            wr_data[d] = '0;
            start[d]   = 1'b0;
            rd_idx[d]  = '0;
        end
        test_reset();
        test_uniform();
        test_two_spikes();
        test_empty_region();
        test_iter_cap();
        test_abort();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lloyd_max_engine.md
Name: lloyd_max_engine

Overview:
- Parametrised iterative Lloyd-Max scalar quantiser designer.
- Holds an internal histogram RAM loaded by the host and, on start, iterates centroid/boundary updates in fixed point until convergence or an iteration cap.
- Exposes the final reconstruction levels and decision boundaries through an indexed read port.
- Successor to the single-configuration fixed-point count/sum/boundary datapath: adds generic level count, precision, convergence test, empty-region handling and a start/done handshake.

Parameters:
DATA_BITS, 8, sample width; histogram has 2^DATA_BITS bins
NUM_LEVELS, 4, quantiser levels L (power of two, 2..16)
FRAC_BITS, 8, fractional bits of levels/boundaries
CNT_BITS, 16, histogram bin count width
MAX_ITER, 16, iteration cap (>=1)
TOL, 1, convergence tolerance in level LSBs (Q DATA_BITS.FRAC_BITS)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
hist_wr_en  in  1  histogram write strobe
hist_wr_addr  in  DATA_BITS  bin index
hist_wr_data  in  CNT_BITS  bin count
start  in  1  single-cycle pulse, begin optimisation
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at completion
converged  out  1  last run ended by tolerance (held until next start)
iter_count  out  8  iterations executed in last run
rd_idx  in  4  level/boundary select
level_out  out  DATA_BITS+FRAC_BITS  level a[rd_idx], registered (1-cycle latency)
boundary_out  out  DATA_BITS+FRAC_BITS  boundary t[rd_idx+1], registered; 0 for rd_idx>=L-1

Behaviour:
- Reset: busy=0, done=0, converged=0, iter_count=0, level_out=0, boundary_out=0, all level/boundary/accumulator regs 0, FSM->IDLE. Histogram RAM contents retained. Reset mid-run aborts immediately.
- hist writes accepted only when busy=0; ignored while busy. start ignored while busy.
- FSM: IDLE -> INIT -> ACCUM -> DIVIDE -> UPDATE -> CHECK -> (ACCUM | DONE) -> IDLE.
- INIT (1 cycle): a[k] = (2k+1)*2^DATA_BITS/(2L) in Q format; t[k] = (a[k-1]+a[k])>>1, k=1..L-1; t[0]=0, t[L]=2^DATA_BITS (implicit). iter_count=0, converged=0.
- ACCUM (exactly 2^DATA_BITS cycles): bin x scanned in ascending order; bin belongs to region r where (x<<FRAC_BITS) < t[r+1], i.e. region index increments when scaled x >= t[r+1]. count[r]+=h[x]; sum[r]+=h[x]*x. count width CNT_BITS+DATA_BITS, sum width CNT_BITS+2*DATA_BITS; no overflow by construction.
- DIVIDE (exactly L*(DATA_BITS+FRAC_BITS+1) cycles): restoring divider per region, 1 load cycle + one quotient bit per cycle; new_a[r] = (sum[r]<<FRAC_BITS)/count[r], truncated. count[r]==0 -> new_a[r]=a[r] (level kept).
- UPDATE (1 cycle): record maxdelta = max|new_a-a|; a=new_a; t[k]=(a[k-1]+a[k])>>1 truncating; iter_count+=1.
- CHECK (1 cycle): maxdelta<=TOL -> converged=1, DONE; else iter_count==MAX_ITER -> DONE with converged=0; else ACCUM (accumulators cleared).
- DONE: done=1 for one cycle, busy=0 same cycle, return IDLE.
- Readout valid whenever busy=0; values during busy are intermediate, not specified.

Test Plan:
- Reset: assert reset 2 cycles -> busy=0, done=0, converged=0, iter_count=0, level_out=0, boundary_out=0.
- Defaults, all 256 bins =1, start -> done after 2 iterations, converged=1; levels 0x1F80,0x5F80,0x9F80,0xDF80; boundaries 0x3F80,0x7F80,0xBF80; done pulse exactly 1 cycle.
- L=2, h[10]=5, h[200]=3, others 0 -> converged=1, iter_count=2, levels 0x0A00,0xC800, boundary 0x6900.
- L=2, only h[5]=4 (empty upper region) -> level1 held 0xC000, level0 0x0500, boundary 0x6280, converged=1, iter_count=2.
- MAX_ITER=1, uniform histogram -> done after one iteration, converged=0, iter_count=1, levels 0x1F80.. as after iteration 1.
- Abort/handshake:
  - reset during ACCUM -> busy=0 next cycle, all outputs at reset values; a fresh start then reproduces the uniform result.
  - start and hist_wr_en while busy -> ignored; results identical to an undisturbed run.
